// File: rtl/waypoint_sequencer_if.sv
// Waypoint sequencer bus: table programming, pose input, controller loop and status.
// master = host/odometry/controller side, slave = the sequencer itself.
interface waypoint_sequencer_if #(
  parameter int N_WIDTH = 17,
  parameter int ADDR_W  = 3
);
  logic                WAYPOINT_SEQUENCER_START_In;
  logic                WAYPOINT_SEQUENCER_ABORT_In;
  logic                WAYPOINT_SEQUENCER_WP_WR_En;
  logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_WP_WR_Addr;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WP_WR_X_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WP_WR_Y_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WP_WR_Z_InBus;
  logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_WP_LAST_In;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_X_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_Y_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_Z_InBus;
  logic                WAYPOINT_SEQUENCER_POSE_VALID_In;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_X_OutBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_Y_OutBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_Z_OutBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_VX_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_VY_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WZ_InBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_VX_OutBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_VY_OutBus;
  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WZ_OutBus;
  logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_WP_INDEX_Out;
  logic                WAYPOINT_SEQUENCER_BUSY_Out;
  logic                WAYPOINT_SEQUENCER_DONE_Out;
  logic                WAYPOINT_SEQUENCER_TIMEOUT_Out;

  modport master (
    output WAYPOINT_SEQUENCER_START_In, WAYPOINT_SEQUENCER_ABORT_In,
           WAYPOINT_SEQUENCER_WP_WR_En, WAYPOINT_SEQUENCER_WP_WR_Addr,
           WAYPOINT_SEQUENCER_WP_WR_X_InBus, WAYPOINT_SEQUENCER_WP_WR_Y_InBus,
           WAYPOINT_SEQUENCER_WP_WR_Z_InBus, WAYPOINT_SEQUENCER_WP_LAST_In,
           WAYPOINT_SEQUENCER_POSE_X_InBus, WAYPOINT_SEQUENCER_POSE_Y_InBus,
           WAYPOINT_SEQUENCER_POSE_Z_InBus, WAYPOINT_SEQUENCER_POSE_VALID_In,
           WAYPOINT_SEQUENCER_VX_InBus, WAYPOINT_SEQUENCER_VY_InBus, WAYPOINT_SEQUENCER_WZ_InBus,
    input  WAYPOINT_SEQUENCER_ERR_X_OutBus, WAYPOINT_SEQUENCER_ERR_Y_OutBus,
           WAYPOINT_SEQUENCER_ERR_Z_OutBus, WAYPOINT_SEQUENCER_VX_OutBus,
           WAYPOINT_SEQUENCER_VY_OutBus, WAYPOINT_SEQUENCER_WZ_OutBus,
           WAYPOINT_SEQUENCER_WP_INDEX_Out, WAYPOINT_SEQUENCER_BUSY_Out,
           WAYPOINT_SEQUENCER_DONE_Out, WAYPOINT_SEQUENCER_TIMEOUT_Out
  );

  modport slave (
    input  WAYPOINT_SEQUENCER_START_In, WAYPOINT_SEQUENCER_ABORT_In,
           WAYPOINT_SEQUENCER_WP_WR_En, WAYPOINT_SEQUENCER_WP_WR_Addr,
           WAYPOINT_SEQUENCER_WP_WR_X_InBus, WAYPOINT_SEQUENCER_WP_WR_Y_InBus,
           WAYPOINT_SEQUENCER_WP_WR_Z_InBus, WAYPOINT_SEQUENCER_WP_LAST_In,
           WAYPOINT_SEQUENCER_POSE_X_InBus, WAYPOINT_SEQUENCER_POSE_Y_InBus,
           WAYPOINT_SEQUENCER_POSE_Z_InBus, WAYPOINT_SEQUENCER_POSE_VALID_In,
           WAYPOINT_SEQUENCER_VX_InBus, WAYPOINT_SEQUENCER_VY_InBus, WAYPOINT_SEQUENCER_WZ_InBus,
    output WAYPOINT_SEQUENCER_ERR_X_OutBus, WAYPOINT_SEQUENCER_ERR_Y_OutBus,
           WAYPOINT_SEQUENCER_ERR_Z_OutBus, WAYPOINT_SEQUENCER_VX_OutBus,
           WAYPOINT_SEQUENCER_VY_OutBus, WAYPOINT_SEQUENCER_WZ_OutBus,
           WAYPOINT_SEQUENCER_WP_INDEX_Out, WAYPOINT_SEQUENCER_BUSY_Out,
           WAYPOINT_SEQUENCER_DONE_Out, WAYPOINT_SEQUENCER_TIMEOUT_Out
  );
endinterface

// File: rtl/waypoint_sequencer.sv
// Steps a velocity controller through a table of (X, Y, theta) waypoints, feeding it
// sign-magnitude pose errors and gating its commands until each waypoint settles.
module waypoint_sequencer #(
  parameter int N_WIDTH        = 17,
  parameter int ADDR_W         = 3,
  parameter int SETTLE_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic                WAYPOINT_SEQUENCER_CLOCK_50,
  input logic                WAYPOINT_SEQUENCER_RESET_InHigh,
  waypoint_sequencer_if.slave bus
);
  localparam int M  = N_WIDTH - 1;
  localparam int SW = $clog2(SETTLE_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LIM = SW'(SETTLE_COUNT);
  localparam logic [TW-1:0] TOUT_LIM   = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_TRACK   = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic                 clk, rst;
  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    index_q, index_d, last_q, last_d;
  logic [N_WIDTH-1:0]   tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d, tgt_z_q, tgt_z_d;
  logic [N_WIDTH-1:0]   err_x_q, err_x_d, err_y_q, err_y_d, err_z_q, err_z_d;
  logic [N_WIDTH-1:0]   vx_q, vx_d, vy_q, vy_d, wz_q, wz_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [TW-1:0]        tout_q, tout_d;
  logic                 eval_q, eval_d;
  logic                 busy, v_zero;
  logic [N_WIDTH-1:0]   tbl_x [2**ADDR_W];
  logic [N_WIDTH-1:0]   tbl_y [2**ADDR_W];
  logic [N_WIDTH-1:0]   tbl_z [2**ADDR_W];

  assign clk = WAYPOINT_SEQUENCER_CLOCK_50;
  assign rst = WAYPOINT_SEQUENCER_RESET_InHigh;

  // target - pose in sign-magnitude: negate pose by flipping its sign, then add
  function automatic logic [N_WIDTH-1:0] sm_sub(input logic [N_WIDTH-1:0] a,
                                                input logic [N_WIDTH-1:0] b);
    logic         nb_s, sgn;
    logic [M:0]   sum;
    logic [M-1:0] mag;
    nb_s = ~b[M];
    sum  = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
    if (a[M] == nb_s) begin
      mag = sum[M] ? '1 : sum[M-1:0];
      sgn = nb_s;
    end else if (a[M-1:0] >= b[M-1:0]) begin
      mag = a[M-1:0] - b[M-1:0];
      sgn = a[M];
    end else begin
      mag = b[M-1:0] - a[M-1:0];
      sgn = nb_s;
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  assign busy   = (state_q == S_FETCH) || (state_q == S_TRACK) || (state_q == S_ADVANCE);
  assign v_zero = (bus.WAYPOINT_SEQUENCER_VX_InBus[M-1:0] == '0) &&
                  (bus.WAYPOINT_SEQUENCER_VY_InBus[M-1:0] == '0) &&
                  (bus.WAYPOINT_SEQUENCER_WZ_InBus[M-1:0] == '0);

  // NOTE: the table is plain storage with no reset branch, so it maps onto RAM and
  // keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (bus.WAYPOINT_SEQUENCER_WP_WR_En && !busy) begin
      tbl_x[bus.WAYPOINT_SEQUENCER_WP_WR_Addr] <= bus.WAYPOINT_SEQUENCER_WP_WR_X_InBus;
      tbl_y[bus.WAYPOINT_SEQUENCER_WP_WR_Addr] <= bus.WAYPOINT_SEQUENCER_WP_WR_Y_InBus;
      tbl_z[bus.WAYPOINT_SEQUENCER_WP_WR_Addr] <= bus.WAYPOINT_SEQUENCER_WP_WR_Z_InBus;
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d  = state_q;
    index_d  = index_q;
    last_d   = last_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    tgt_z_d  = tgt_z_q;
    err_x_d  = err_x_q;
    err_y_d  = err_y_q;
    err_z_d  = err_z_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    wz_d     = wz_q;
    settle_d = settle_q;
    tout_d   = tout_q;
    eval_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (bus.WAYPOINT_SEQUENCER_START_In) begin
          state_d = S_FETCH;
          index_d = '0;
          last_d  = bus.WAYPOINT_SEQUENCER_WP_LAST_In;
        end
      end
      S_FETCH: begin
        tgt_x_d  = tbl_x[index_q];
        tgt_y_d  = tbl_y[index_q];
        tgt_z_d  = tbl_z[index_q];
        settle_d = '0;
        tout_d   = '0;
        state_d  = S_TRACK;
      end
      S_TRACK: begin
        tout_d = tout_q + 1'b1;
        if (bus.WAYPOINT_SEQUENCER_POSE_VALID_In) begin
          err_x_d = sm_sub(tgt_x_q, bus.WAYPOINT_SEQUENCER_POSE_X_InBus);
          err_y_d = sm_sub(tgt_y_q, bus.WAYPOINT_SEQUENCER_POSE_Y_InBus);
          err_z_d = sm_sub(tgt_z_q, bus.WAYPOINT_SEQUENCER_POSE_Z_InBus);
          eval_d  = 1'b1;
        end
        // eval cycle: the controller's commands now reflect the fresh error
        if (eval_q) begin
          vx_d = bus.WAYPOINT_SEQUENCER_VX_InBus;
          vy_d = bus.WAYPOINT_SEQUENCER_VY_InBus;
          wz_d = bus.WAYPOINT_SEQUENCER_WZ_InBus;
          if (v_zero) begin
            settle_d = settle_q + 1'b1;
            if (settle_d == SETTLE_LIM) state_d = S_ADVANCE;
          end else begin
            settle_d = '0;
          end
        end
        if (tout_d == TOUT_LIM) state_d = S_FAULT;
      end
      S_ADVANCE: begin
        if (index_q == last_q) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.WAYPOINT_SEQUENCER_ABORT_In) begin
      state_d = S_IDLE;
      index_d = '0;
    end
    // error and command outputs are only live while tracking
    if (state_d != S_TRACK) begin
      err_x_d = '0;
      err_y_d = '0;
      err_z_d = '0;
      vx_d    = '0;
      vy_d    = '0;
      wz_d    = '0;
      eval_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      last_q   <= '0;
      tgt_x_q  <= '0;
      tgt_y_q  <= '0;
      tgt_z_q  <= '0;
      err_x_q  <= '0;
      err_y_q  <= '0;
      err_z_q  <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      wz_q     <= '0;
      settle_q <= '0;
      tout_q   <= '0;
      eval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      last_q   <= last_d;
      tgt_x_q  <= tgt_x_d;
      tgt_y_q  <= tgt_y_d;
      tgt_z_q  <= tgt_z_d;
      err_x_q  <= err_x_d;
      err_y_q  <= err_y_d;
      err_z_q  <= err_z_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      wz_q     <= wz_d;
      settle_q <= settle_d;
      tout_q   <= tout_d;
      eval_q   <= eval_d;
    end
  end

  assign bus.WAYPOINT_SEQUENCER_ERR_X_OutBus = err_x_q;
  assign bus.WAYPOINT_SEQUENCER_ERR_Y_OutBus = err_y_q;
  assign bus.WAYPOINT_SEQUENCER_ERR_Z_OutBus = err_z_q;
  assign bus.WAYPOINT_SEQUENCER_VX_OutBus    = vx_q;
  assign bus.WAYPOINT_SEQUENCER_VY_OutBus    = vy_q;
  assign bus.WAYPOINT_SEQUENCER_WZ_OutBus    = wz_q;
  assign bus.WAYPOINT_SEQUENCER_WP_INDEX_Out = index_q;
  assign bus.WAYPOINT_SEQUENCER_BUSY_Out     = busy;
  assign bus.WAYPOINT_SEQUENCER_DONE_Out     = (state_q == S_DONE);
  assign bus.WAYPOINT_SEQUENCER_TIMEOUT_Out  = (state_q == S_FAULT);
endmodule

// File: tb/tb_waypoint_sequencer.sv
// Bench for waypoint_sequencer: randomized targets/poses checked against an integer
// arithmetic model of signed subtraction, plus settle, multi-waypoint, timeout and abort scenarios.
module tb_waypoint_sequencer;
  localparam int N   = 17;
  localparam int AW  = 3;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [N-1:0] mx [8];
  logic [N-1:0] my [8];
  logic [N-1:0] mz [8];

  always #5 clk = ~clk;

  waypoint_sequencer_if #(.N_WIDTH(N), .ADDR_W(AW)) wif ();

  waypoint_sequencer #(
    .N_WIDTH(N), .ADDR_W(AW), .SETTLE_COUNT(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .WAYPOINT_SEQUENCER_CLOCK_50     (clk),
    .WAYPOINT_SEQUENCER_RESET_InHigh (rst),
    .bus                             (wif.slave)
  );

  // reference: treat values as signed integers, subtract, clamp magnitude
  function automatic logic [N-1:0] ref_sub(input logic [N-1:0] t, input logic [N-1:0] p);
    int tv, pv, d, m;
    tv = t[N-1] ? -int'(t[N-2:0]) : int'(t[N-2:0]);
    pv = p[N-1] ? -int'(p[N-2:0]) : int'(p[N-2:0]);
    d  = tv - pv;
    m  = (d < 0) ? -d : d;
    if (m > 65535) m = 65535;
    if (m == 0) return '0;
    return {(d < 0), 16'(m)};
  endfunction

  function automatic logic [N-1:0] rand_sm();
    logic [N-2:0] m;
    m = 16'($urandom);
    if ($urandom_range(0, 3) == 0) m = '0;
    return {1'($urandom_range(0, 1)), m};
  endfunction

  function automatic logic [N-1:0] rand_nz();
    return {1'($urandom_range(0, 1)), 16'($urandom_range(1, 65535))};
  endfunction

  function automatic logic [3*N-1:0] err_all();
    return {wif.WAYPOINT_SEQUENCER_ERR_X_OutBus, wif.WAYPOINT_SEQUENCER_ERR_Y_OutBus,
            wif.WAYPOINT_SEQUENCER_ERR_Z_OutBus};
  endfunction

  function automatic logic [3*N-1:0] v_all();
    return {wif.WAYPOINT_SEQUENCER_VX_OutBus, wif.WAYPOINT_SEQUENCER_VY_OutBus,
            wif.WAYPOINT_SEQUENCER_WZ_OutBus};
  endfunction

  function automatic logic [5:0] status();
    return {wif.WAYPOINT_SEQUENCER_WP_INDEX_Out, wif.WAYPOINT_SEQUENCER_BUSY_Out,
            wif.WAYPOINT_SEQUENCER_DONE_Out, wif.WAYPOINT_SEQUENCER_TIMEOUT_Out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wif.WAYPOINT_SEQUENCER_START_In      = 1'b0;
    wif.WAYPOINT_SEQUENCER_ABORT_In      = 1'b0;
    wif.WAYPOINT_SEQUENCER_WP_WR_En      = 1'b0;
    wif.WAYPOINT_SEQUENCER_WP_WR_Addr    = '0;
    wif.WAYPOINT_SEQUENCER_WP_WR_X_InBus = '0;
    wif.WAYPOINT_SEQUENCER_WP_WR_Y_InBus = '0;
    wif.WAYPOINT_SEQUENCER_WP_WR_Z_InBus = '0;
    wif.WAYPOINT_SEQUENCER_WP_LAST_In    = '0;
    wif.WAYPOINT_SEQUENCER_POSE_X_InBus  = '0;
    wif.WAYPOINT_SEQUENCER_POSE_Y_InBus  = '0;
    wif.WAYPOINT_SEQUENCER_POSE_Z_InBus  = '0;
    wif.WAYPOINT_SEQUENCER_POSE_VALID_In = 1'b0;
    wif.WAYPOINT_SEQUENCER_VX_InBus      = '0;
    wif.WAYPOINT_SEQUENCER_VY_InBus      = '0;
    wif.WAYPOINT_SEQUENCER_WZ_InBus      = '0;
  endtask

  task automatic write_wp(input int i, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] z);
    wif.WAYPOINT_SEQUENCER_WP_WR_En      = 1'b1;
    wif.WAYPOINT_SEQUENCER_WP_WR_Addr    = AW'(i);
    wif.WAYPOINT_SEQUENCER_WP_WR_X_InBus = x;
    wif.WAYPOINT_SEQUENCER_WP_WR_Y_InBus = y;
    wif.WAYPOINT_SEQUENCER_WP_WR_Z_InBus = z;
    tick();
    wif.WAYPOINT_SEQUENCER_WP_WR_En      = 1'b0;
  endtask

  task automatic model_wp(input int i, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] z);
    mx[i] = x;
    my[i] = y;
    mz[i] = z;
    write_wp(i, x, y, z);
  endtask

  // returns with the sequencer in FETCH
  task automatic start_run(input logic [AW-1:0] last);
    wif.WAYPOINT_SEQUENCER_START_In   = 1'b1;
    wif.WAYPOINT_SEQUENCER_WP_LAST_In = last;
    tick();
    wif.WAYPOINT_SEQUENCER_START_In   = 1'b0;
  endtask

  task automatic abort_run();
    wif.WAYPOINT_SEQUENCER_ABORT_In = 1'b1;
    tick();
    wif.WAYPOINT_SEQUENCER_ABORT_In = 1'b0;
  endtask

  // one pose strobe, then one eval cycle with the given controller commands
  task automatic pose_eval(input logic [N-1:0] px, input logic [N-1:0] py, input logic [N-1:0] pz,
                           input logic [N-1:0] vx, input logic [N-1:0] vy, input logic [N-1:0] wz,
                           output logic [3*N-1:0] err);
    wif.WAYPOINT_SEQUENCER_POSE_X_InBus  = px;
    wif.WAYPOINT_SEQUENCER_POSE_Y_InBus  = py;
    wif.WAYPOINT_SEQUENCER_POSE_Z_InBus  = pz;
    wif.WAYPOINT_SEQUENCER_POSE_VALID_In = 1'b1;
    tick();
    wif.WAYPOINT_SEQUENCER_POSE_VALID_In = 1'b0;
    err = err_all();
    wif.WAYPOINT_SEQUENCER_VX_InBus = vx;
    wif.WAYPOINT_SEQUENCER_VY_InBus = vy;
    wif.WAYPOINT_SEQUENCER_WZ_InBus = wz;
    tick();
  endtask

  task automatic test_reset();
    logic [3*N-1:0] e;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    n_total++;
    if ({err_all(), v_all(), status()} !== '0) $display("FAIL reset_outputs: got %h expected 0", {err_all(), v_all(), status()});
    else n_pass++;
    // reset from mid-run must return to idle but keep the table
    model_wp(0, 17'h00A00, 17'h10300, 17'h00001);
    start_run(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (status() !== '0) $display("FAIL reset_midrun: got %h expected 0", status());
    else n_pass++;
    start_run(0);
    tick();
    pose_eval('0, '0, '0, 17'h00100, '0, '0, e);
    n_total++;
    if (e !== {mx[0], my[0], mz[0]}) $display("FAIL reset_keeps_table: got %h expected %h", e, {mx[0], my[0], mz[0]});
    else n_pass++;
    abort_run();
  endtask

  task automatic test_basic();
    logic [3*N-1:0] e;
    model_wp(0, 17'h00000, 17'h03200, 17'h00000);
    start_run(0);
    tick();
    pose_eval('0, '0, '0, 17'h01900, '0, '0, e);
    n_total++;
    if (e !== {17'h00000, 17'h03200, 17'h00000}) $display("FAIL basic_err: got %h expected %h", e, {17'h00000, 17'h03200, 17'h00000});
    else n_pass++;
    n_total++;
    if ({v_all(), wif.WAYPOINT_SEQUENCER_BUSY_Out} !== {17'h01900, 17'h0, 17'h0, 1'b1})
      $display("FAIL basic_v_busy: got %h expected %h", {v_all(), wif.WAYPOINT_SEQUENCER_BUSY_Out}, {17'h01900, 17'h0, 17'h0, 1'b1});
    else n_pass++;
    abort_run();
  endtask

  task automatic test_arith();
    logic [N-1:0] dt [3] = '{17'h00500, 17'h1A5A5, 17'h0C800};
    logic [N-1:0] dp [3] = '{17'h01400, 17'h1A5A5, 17'h1C800};
    logic [N-1:0] de [3] = '{17'h10F00, 17'h00000, 17'h0FFFF};
    logic [N-1:0] tx, px, py, pz;
    logic [3*N-1:0] e;
    for (int i = 0; i < 13; i++) begin
      tx = (i < 3) ? dt[i] : rand_sm();
      px = (i < 3) ? dp[i] : rand_sm();
      py = rand_sm();
      pz = rand_sm();
      model_wp(0, tx, rand_sm(), rand_sm());
      start_run(0);
      tick();
      pose_eval(px, py, pz, 17'h00100, '0, '0, e);
      n_total++;
      if (e !== {ref_sub(mx[0], px), ref_sub(my[0], py), ref_sub(mz[0], pz)})
        $display("FAIL arith_%0d: got %h expected %h", i, e, {ref_sub(mx[0], px), ref_sub(my[0], py), ref_sub(mz[0], pz)});
      else n_pass++;
      if (i < 3) begin
        n_total++;
        if (e[3*N-1:2*N] !== de[i]) $display("FAIL arith_literal_%0d: got %h expected %h", i, e[3*N-1:2*N], de[i]);
        else n_pass++;
      end
      abort_run();
    end
  endtask

  task automatic test_settle();
    bit zero_seq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] vx, vy, wz;
    logic [3*N-1:0] e, held;
    int cnt = 0;
    model_wp(0, rand_sm(), rand_sm(), rand_sm());
    start_run(0);
    tick();
    for (int k = 0; k < 7; k++) begin
      vx = zero_seq[k] ? '0 : rand_nz();
      vy = zero_seq[k] ? '0 : rand_nz();
      wz = zero_seq[k] ? ((k == 0) ? 17'h10000 : '0) : rand_nz();
      cnt = zero_seq[k] ? cnt + 1 : 0;
      pose_eval(rand_sm(), rand_sm(), rand_sm(), vx, vy, wz, e);
      if (cnt < 4) begin
        n_total++;
        if ({v_all(), wif.WAYPOINT_SEQUENCER_BUSY_Out, wif.WAYPOINT_SEQUENCER_DONE_Out} !== {vx, vy, wz, 2'b10})
          $display("FAIL settle_eval_%0d: got %h expected %h", k, {v_all(), wif.WAYPOINT_SEQUENCER_BUSY_Out, wif.WAYPOINT_SEQUENCER_DONE_Out}, {vx, vy, wz, 2'b10});
        else n_pass++;
      end
      if (!zero_seq[k]) begin
        held = {vx, vy, wz};
        for (int j = 0; j < 3; j++) begin
          wif.WAYPOINT_SEQUENCER_VX_InBus = rand_nz();
          tick();
        end
        n_total++;
        if (v_all() !== held) $display("FAIL settle_v_hold: got %h expected %h", v_all(), held);
        else n_pass++;
      end
    end
    n_total++;
    if ({v_all(), wif.WAYPOINT_SEQUENCER_BUSY_Out, wif.WAYPOINT_SEQUENCER_DONE_Out} !== {51'h0, 2'b10})
      $display("FAIL settle_advance: got %h expected %h", {v_all(), wif.WAYPOINT_SEQUENCER_BUSY_Out, wif.WAYPOINT_SEQUENCER_DONE_Out}, {51'h0, 2'b10});
    else n_pass++;
    tick();
    n_total++;
    if ({err_all(), v_all(), status()} !== {102'h0, 3'd0, 3'b010})
      $display("FAIL settle_done: got %h expected %h", {err_all(), v_all(), status()}, {102'h0, 3'd0, 3'b010});
    else n_pass++;
  endtask

  task automatic test_multi();
    logic [N-1:0] px, py, pz;
    logic [3*N-1:0] e;
    for (int w = 0; w < 3; w++) model_wp(w, rand_sm(), rand_sm(), rand_sm());
    start_run(2);
    for (int w = 0; w < 3; w++) begin
      n_total++;
      if ({err_all(), status()} !== {51'h0, 3'(w), 3'b100})
        $display("FAIL multi_fetch_%0d: got %h expected %h", w, {err_all(), status()}, {51'h0, 3'(w), 3'b100});
      else n_pass++;
      tick();
      for (int k = 0; k < 4; k++) begin
        px = rand_sm();
        py = rand_sm();
        pz = rand_sm();
        pose_eval(px, py, pz, '0, '0, '0, e);
        n_total++;
        if (e !== {ref_sub(mx[w], px), ref_sub(my[w], py), ref_sub(mz[w], pz)})
          $display("FAIL multi_err_%0d_%0d: got %h expected %h", w, k, e, {ref_sub(mx[w], px), ref_sub(my[w], py), ref_sub(mz[w], pz)});
        else n_pass++;
      end
      tick();
    end
    for (int j = 0; j < 5; j++) tick();
    n_total++;
    if (status() !== {3'd2, 3'b010}) $display("FAIL multi_done: got %h expected %h", status(), {3'd2, 3'b010});
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n = 0;
    model_wp(0, rand_sm(), rand_sm(), rand_sm());
    start_run(0);
    tick();
    wif.WAYPOINT_SEQUENCER_VX_InBus = 17'h00200;
    while (!wif.WAYPOINT_SEQUENCER_TIMEOUT_Out && n < 3 * TMO) begin
      wif.WAYPOINT_SEQUENCER_POSE_VALID_In = (n % 3 == 0);
      tick();
      n++;
    end
    wif.WAYPOINT_SEQUENCER_POSE_VALID_In = 1'b0;
    n_total++;
    if (n !== TMO) $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO);
    else n_pass++;
    n_total++;
    if ({err_all(), v_all(), status()} !== {102'h0, 3'd0, 3'b001})
      $display("FAIL timeout_fault: got %h expected %h", {err_all(), v_all(), status()}, {102'h0, 3'd0, 3'b001});
    else n_pass++;
    start_run(0);
    n_total++;
    if (status() !== {3'd0, 3'b100}) $display("FAIL timeout_restart: got %h expected %h", status(), {3'd0, 3'b100});
    else n_pass++;
    abort_run();
  endtask

  task automatic test_abort();
    logic [3*N-1:0] e;
    model_wp(0, 17'h00000, 17'h03200, 17'h00000);
    start_run(0);
    tick();
    pose_eval('0, '0, '0, 17'h01900, '0, '0, e);
    n_total++;
    if (wif.WAYPOINT_SEQUENCER_VX_OutBus !== 17'h01900) $display("FAIL abort_pre_vx: got %h expected %h", wif.WAYPOINT_SEQUENCER_VX_OutBus, 17'h01900);
    else n_pass++;
    abort_run();
    n_total++;
    if ({err_all(), v_all(), status()} !== '0) $display("FAIL abort_zero: got %h expected 0", {err_all(), v_all(), status()});
    else n_pass++;
    wif.WAYPOINT_SEQUENCER_START_In = 1'b1;
    wif.WAYPOINT_SEQUENCER_ABORT_In = 1'b1;
    tick();
    wif.WAYPOINT_SEQUENCER_START_In = 1'b0;
    wif.WAYPOINT_SEQUENCER_ABORT_In = 1'b0;
    tick();
    n_total++;
    if (status() !== '0) $display("FAIL abort_beats_start: got %h expected 0", status());
    else n_pass++;
    // write while busy must be dropped; model keeps the original entry
    start_run(0);
    tick();
    write_wp(0, 17'h07777, 17'h17777, 17'h01111);
    abort_run();
    start_run(0);
    tick();
    pose_eval('0, '0, '0, 17'h00100, '0, '0, e);
    n_total++;
    if (e !== {mx[0], my[0], mz[0]}) $display("FAIL abort_busy_write: got %h expected %h", e, {mx[0], my[0], mz[0]});
    else n_pass++;
    abort_run();
    wif.WAYPOINT_SEQUENCER_POSE_VALID_In = 1'b1;
    wif.WAYPOINT_SEQUENCER_POSE_X_InBus  = 17'h01234;
    tick();
    wif.WAYPOINT_SEQUENCER_POSE_VALID_In = 1'b0;
    tick();
    n_total++;
    if ({err_all(), v_all(), status()} !== '0) $display("FAIL idle_pose_ignored: got %h expected 0", {err_all(), v_all(), status()});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_settle();
    test_multi();
    test_timeout();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
